mem_wb_writeback: RTL

//  MEM->WB pipeline register and register-file write-back driver for the pipelined core.

---
 rtl/mem_wb_writeback.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_wb_writeback.sv
// ---------------------------------------------------------------------------
// mem_wb_writeback
//
// MEM->WB pipeline register and register-file write-back driver.
//
// The block accepts retiring instructions from the MEM stage. An instruction
// that is not a load produces its write-back strobe one cycle after it is
// accepted. A load holds the stage in WAIT_LOAD until its memory data
// arrives, the load is flushed, or the wait times out. While the load is
// pending, its destination register is exported so that the ID-stage hazard
// logic can stall.
//
// Handshake (valid/ready):
//   An instruction transfers on a rising edge where valid_MEM && ready_MEM
//   && !flush. ready_MEM depends only on registered state and never on
//   valid_MEM. A transfer presented together with flush is dropped.
//
// Ports:
//   clk                  in   1       clock; all state changes on the rising edge
//   reset                in   1       asynchronous, active-low reset
//   valid_MEM            in   1       MEM stage presents an instruction
//   ready_MEM            out  1       stage can accept (high only in IDLE)
//   flush                in   1       squash the accepted or pending instruction
//   regwBoolean_MEM      in   1       instruction writes a register
//   MemrBoolean_MEM      in   1       instruction is a load
//   regselectordest_MEM  in   REG_AW  destination register
//   ALUResult_MEM        in   DATA_W  result of a non-load instruction
//   ReadData_MEM         in   DATA_W  data-memory read data
//   rdata_valid          in   1       ReadData_MEM is valid this cycle
//   regwBoolean_WB       out  1       register-file write strobe, one-cycle pulse
//   regselectordest_WB   out  REG_AW  write destination (holds between strobes)
//   FinalResult_WB       out  DATA_W  write data (holds between strobes)
//   pcwrite_WB           out  1       strobe whose destination is R15 (the PC)
//   busy_WB              out  1       a load is pending (the FSM is in WAIT_LOAD)
//   pend_dest_WB         out  REG_AW  destination of the pending load, 0 when idle
//   err_WB               out  1       one-cycle pulse when a load times out
//   retired_WB           out  32      number of strobes issued; wraps to 0
// ---------------------------------------------------------------------------
module mem_wb_writeback #(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 4,
    parameter int LOAD_TIMEOUT = 15   // legal range 1..255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_MEM,
    output logic              ready_MEM,
    input  logic              flush,
    input  logic              regwBoolean_MEM,
    input  logic              MemrBoolean_MEM,
    input  logic [REG_AW-1:0] regselectordest_MEM,
    input  logic [DATA_W-1:0] ALUResult_MEM,
    input  logic [DATA_W-1:0] ReadData_MEM,
    input  logic              rdata_valid,
    output logic              regwBoolean_WB,
    output logic [REG_AW-1:0] regselectordest_WB,
    output logic [DATA_W-1:0] FinalResult_WB,
    output logic              pcwrite_WB,
    output logic              busy_WB,
    output logic [REG_AW-1:0] pend_dest_WB,
    output logic              err_WB,
    output logic [31:0]       retired_WB
);

    localparam int                CNT_W       = 8;
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(LOAD_TIMEOUT);
    localparam logic [REG_AW-1:0] PC_REG      = REG_AW'(15);

    // The FSM has two states. busy_WB is a direct decode of the state
    // register, so it also serves as the state debug output.
    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } state_t;

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [REG_AW-1:0]   pend_dest_q, pend_dest_d;
    logic                pend_regw_q, pend_regw_d;
    logic                regw_q,      regw_d;
    logic [REG_AW-1:0]   dest_q,      dest_d;
    logic [DATA_W-1:0]   result_q,    result_d;
    logic                pcw_q,       pcw_d;
    logic                err_q,       err_d;
    logic [31:0]         retired_q,   retired_d;

    logic                accept;
    logic [CNT_W-1:0]    cnt_inc;

    // A flushed transfer never reaches the FSM.
    assign accept  = valid_MEM && (state_q == S_IDLE) && !flush;
    assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_dest_d = pend_dest_q;
        pend_regw_d = pend_regw_q;
        // The strobe and the error are pulses and default low every cycle.
        // The destination and data registers hold until the next strobe.
        regw_d      = 1'b0;
        dest_d      = dest_q;
        result_d    = result_q;
        err_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // rdata_valid has no effect in IDLE.
                if (accept) begin
                    if (MemrBoolean_MEM) begin
                        state_d     = S_WAIT_LOAD;
                        pend_dest_d = regselectordest_MEM;
                        pend_regw_d = regwBoolean_MEM;
                        cnt_d       = '0;
                    end else if (regwBoolean_MEM) begin
                        regw_d   = 1'b1;
                        dest_d   = regselectordest_MEM;
                        result_d = ALUResult_MEM;
                    end
                end
            end

            S_WAIT_LOAD: begin
                cnt_d = cnt_inc;
                if (flush) begin
                    // Flush wins over data that arrives in the same cycle.
                    state_d = S_IDLE;
                end else if (rdata_valid) begin
                    state_d = S_IDLE;
                    // A load without a register write consumes its data silently.
                    if (pend_regw_q) begin
                        regw_d   = 1'b1;
                        dest_d   = pend_dest_q;
                        result_d = ReadData_MEM;
                    end
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    // LOAD_TIMEOUT cycles have passed in WAIT_LOAD with no data.
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // pcwrite and the retire count follow the strobe being registered, so
    // both change in the same cycle that regwBoolean_WB goes high.
    always_comb begin
        pcw_d     = regw_d && (dest_d == PC_REG);
        retired_d = retired_q + {31'b0, regw_d};
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pend_dest_q <= '0;
            pend_regw_q <= 1'b0;
            regw_q      <= 1'b0;
            dest_q      <= '0;
            result_q    <= '0;
            pcw_q       <= 1'b0;
            err_q       <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_dest_q <= pend_dest_d;
            pend_regw_q <= pend_regw_d;
            regw_q      <= regw_d;
            dest_q      <= dest_d;
            result_q    <= result_d;
            pcw_q       <= pcw_d;
            err_q       <= err_d;
            retired_q   <= retired_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ready_MEM          = (state_q == S_IDLE);
    assign busy_WB            = (state_q == S_WAIT_LOAD);
    // Report 0 when no load is pending, so the ID stage compares against R0 only.
    assign pend_dest_WB       = busy_WB ? pend_dest_q : '0;
    assign regwBoolean_WB     = regw_q;
    assign regselectordest_WB = dest_q;
    assign FinalResult_WB     = result_q;
    assign pcwrite_WB         = pcw_q;
    assign err_WB             = err_q;
    assign retired_WB         = retired_q;

endmodule
